// File: rtl/pixel_writer_pkg.sv
// Shared types and constants for the pixel writer slice.
// Optional cycle counter is enabled by PIXEL_WRITER_CYCLE_COUNT_EN.
package pixel_writer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_WRITE,
    S_HANDSHAKE,
    S_FINISHED
  } state_t;

  localparam int PAL_N = 8;

  localparam logic [7:0] PALETTE [PAL_N] = '{
    8'h00, 8'h03, 8'h1F, 8'h1C,
    8'hFC, 8'hE0, 8'hE3, 8'hFF
  };

  localparam logic [7:0] BLACK = 8'h00;

endpackage

// File: rtl/pixel_writer_if.sv
// Frame-buffer write port: request/ack handshake
// from the pixel writer to the VGA frame buffer.
interface pixel_writer_if #(
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 8
) ();

  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [COLOR_W-1:0] wr_data;
  logic               wr_ack;

  modport master (
    output wr_en, wr_addr, wr_data,
    input  wr_ack
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    output wr_ack
  );

endinterface

// File: rtl/pixel_writer_color_map.sv
// Iteration count to colour: black when in-set,
// otherwise a palette entry picked by log2(iterations+1).
module pixel_writer_color_map
  import pixel_writer_pkg::*;
#(
  parameter int COLOR_W = 8
) (
  input  logic [31:0]        iterations,
  input  logic [31:0]        max_iterations,
  output logic [COLOR_W-1:0] color
);

  logic [2:0] b;

  // Bucket edges sit at 2^k - 1; anything past 126 clamps to 7.
  always_comb begin
    b = 3'd0;
    unique case (1'b1)
      (iterations >= 32'd127):
        b = 3'd7;
      (iterations >= 32'd63) && (iterations < 32'd127):
        b = 3'd6;
      (iterations >= 32'd31) && (iterations < 32'd63):
        b = 3'd5;
      (iterations >= 32'd15) && (iterations < 32'd31):
        b = 3'd4;
      (iterations >= 32'd7) && (iterations < 32'd15):
        b = 3'd3;
      (iterations >= 32'd3) && (iterations < 32'd7):
        b = 3'd2;
      (iterations >= 32'd1) && (iterations < 32'd3):
        b = 3'd1;
      default:
        b = 3'd0;
    endcase
  end

  assign color = (iterations >= max_iterations)
               ? COLOR_W'(BLACK)
               : COLOR_W'(PALETTE[b]);

endmodule

// File: rtl/pixel_writer.sv
// Consumes iterator results and writes colours in raster order.
// Define PIXEL_WRITER_CYCLE_COUNT_EN to enable frame_cycles.
module pixel_writer
  import pixel_writer_pkg::*;
#(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               done,
  input  logic               all_done,
  input  logic [31:0]        iterations,
  input  logic [31:0]        max_iterations,
  output logic               handshake,
  pixel_writer_if.master     fb,
  output logic [31:0]        pixel_count,
  output logic               frame_done,
  output logic [31:0]        frame_cycles
);

  localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  state_t             state;
  logic [ADDR_W-1:0]  addr;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [COLOR_W-1:0] color_q;
  logic [COLOR_W-1:0] color_next;
  logic               wr_en_q;

  pixel_writer_color_map #(
    .COLOR_W(COLOR_W)
  ) u_color_map (
    .iterations    (iterations),
    .max_iterations(max_iterations),
    .color         (color_next)
  );

  assign fb.wr_en   = wr_en_q;
  assign fb.wr_addr = wr_en_q ? addr : '0;
  assign fb.wr_data = wr_en_q ? color_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      addr        <= '0;
      x           <= '0;
      y           <= '0;
      color_q     <= '0;
      wr_en_q     <= 1'b0;
      handshake   <= 1'b0;
      pixel_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      handshake <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (done) begin
            state <= S_CAPTURE;
          end else if (all_done) begin
            state      <= S_FINISHED;
            frame_done <= 1'b1;
          end
        end
        S_CAPTURE: begin
          color_q <= color_next;
          wr_en_q <= 1'b1;
          state   <= S_WRITE;
        end
        S_WRITE: begin
          if (fb.wr_ack) begin
            wr_en_q     <= 1'b0;
            handshake   <= 1'b1;
            pixel_count <= pixel_count + 32'd1;
            state       <= S_HANDSHAKE;
            // Last pixel of the frame wraps back to the origin.
            if (x == X_LAST && y == Y_LAST) begin
              addr <= '0;
              x    <= '0;
              y    <= '0;
            end else if (x == X_LAST) begin
              addr <= addr + 1'b1;
              x    <= '0;
              y    <= y + 1'b1;
            end else begin
              addr <= addr + 1'b1;
              x    <= x + 1'b1;
            end
          end
        end
        S_HANDSHAKE: state <= S_IDLE;
        S_FINISHED:  state <= S_FINISHED;
        default:     state <= S_IDLE;
      endcase
    end
  end

`ifdef PIXEL_WRITER_CYCLE_COUNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
    end else if (state != S_FINISHED) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign frame_cycles = cyc_q;
`else
  assign frame_cycles = '0;
`endif

endmodule

// File: tb/tb_pixel_writer.sv
// Randomised scoreboard bench for pixel_writer on a 4x2 frame.
// Honours PIXEL_WRITER_CYCLE_COUNT_EN for frame_cycles expectations.
module tb_pixel_writer;

  localparam int H = 4;
  localparam int V = 2;
  localparam int AW = 3;
  localparam int CW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        done;
  logic        all_done;
  logic [31:0] iterations;
  logic [31:0] max_iterations;
  logic        handshake;
  logic [31:0] pixel_count;
  logic        frame_done;
  logic [31:0] frame_cycles;

  pixel_writer_if #(.ADDR_W(AW), .COLOR_W(CW)) fb_if ();

  pixel_writer #(
    .H_RES(H), .V_RES(V), .ADDR_W(AW), .COLOR_W(CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .done          (done),
    .all_done      (all_done),
    .iterations    (iterations),
    .max_iterations(max_iterations),
    .handshake     (handshake),
    .fb            (fb_if),
    .pixel_count   (pixel_count),
    .frame_done    (frame_done),
    .frame_cycles  (frame_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int idx = 0;
  int exp_count = 0;
  int exp_cyc = 0;
  logic fd_s = 1'b0;
  logic [AW+CW-1:0] sb [$];
  logic [7:0] pal [8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_color(input logic [31:0] it,
                                           input logic [31:0] mx);
    logic [63:0] v;
    int b;
    if (it >= mx) return 8'h00;
    v = 64'(it) + 64'd1;
    b = 0;
    while (b < 7 && (64'd1 << (b + 1)) <= v) b++;
    return pal[b];
  endfunction

  // Reference cycle counter: every edge out of reset while not finished.
  always @(negedge clk) fd_s = frame_done;
  always @(posedge clk or posedge rst) begin
    if (rst) exp_cyc = 0;
    else if (!fd_s) exp_cyc++;
  end

  // Monitor: checks every accepted write against the scoreboard.
  always @(negedge clk) begin
    #2;
    if (fb_if.wr_en && fb_if.wr_ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        logic [AW+CW-1:0] e;
        e = sb.pop_front();
        chk("wr_addr", 32'(fb_if.wr_addr), 32'(e[AW+CW-1:CW]));
        chk("wr_data", 32'(fb_if.wr_data), 32'(e[CW-1:0]));
        exp_count++;
      end
    end
    if (handshake) chk("pixel_count", pixel_count, 32'(exp_count));
  end

  task automatic send(input logic [31:0] it, input logic [31:0] mx,
                      input int stall);
    int n;
    int st;
    bit got;
    bit first;
    logic [AW-1:0] a0;
    logic [CW-1:0] d0;
    sb.push_back({AW'(idx % (H * V)), ref_color(it, mx)});
    idx++;
    n = 0; st = 0; got = 0; first = 1;
    a0 = '0; d0 = '0;
    done = 1'b1;
    iterations = it;
    max_iterations = mx;
    @(posedge clk);
    while (!got && n < 60) begin
      @(negedge clk);
      if (handshake) begin
        got = 1;
      end else begin
        if (fb_if.wr_en) begin
          if (first) begin
            a0 = fb_if.wr_addr;
            d0 = fb_if.wr_data;
            first = 0;
          end else begin
            chk("stall_addr", 32'(fb_if.wr_addr), 32'(a0));
            chk("stall_data", 32'(fb_if.wr_data), 32'(d0));
          end
          if (st < stall) begin
            fb_if.wr_ack = 1'b0;
            st++;
          end else begin
            fb_if.wr_ack = 1'b1;
          end
        end
        @(posedge clk);
        n++;
      end
    end
    if (!got) chk("hs_timeout", 32'd0, 32'd1);
    else chk("hs_latency", 32'(n), 32'(2 + stall));
    done = 1'b0;
    fb_if.wr_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("hs_pulse", 32'(handshake), 32'd0);
  endtask

  initial begin
    int hs_seen;
    int w;
    pal = '{8'h00, 8'h03, 8'h1F, 8'h1C, 8'hFC, 8'hE0, 8'hE3, 8'hFF};
    rst = 1'b1;
    done = 1'b0;
    all_done = 1'b0;
    iterations = '0;
    max_iterations = '0;
    fb_if.wr_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_handshake", 32'(handshake), 32'd0);
    chk("rst_wr_en", 32'(fb_if.wr_en), 32'd0);
    chk("rst_pixel_count", pixel_count, 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_cycles", frame_cycles, 32'd0);
    rst = 1'b0;

    send(32'd1000, 32'd1000, 0);
    send(32'd0, 32'd1000, 0);
    send(32'd2, 32'd1000, 1);
    send(32'd6, 32'd1000, 0);
    send(32'd200, 32'd1000, 5);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] it;
      logic [31:0] mx;
      it = $urandom_range(0, 300);
      case ($urandom % 3)
        0: mx = 32'd0;
        1: mx = 32'd1000;
        default: mx = $urandom_range(0, 300);
      endcase
      send(it, mx, int'($urandom_range(0, 5)));
    end
    chk("total_pixels", pixel_count, 32'd9);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    all_done = 1'b1;
    repeat (3) @(negedge clk);
    chk("frame_done", 32'(frame_done), 32'd1);
    chk("fin_wr_en", 32'(fb_if.wr_en), 32'd0);
    done = 1'b1;
    hs_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (handshake || fb_if.wr_en) hs_seen++;
    end
    chk("late_done_ignored", 32'(hs_seen), 32'd0);
    chk("fin_pixel_count", pixel_count, 32'd9);
`ifdef PIXEL_WRITER_CYCLE_COUNT_EN
    chk("frame_cycles", frame_cycles, 32'(exp_cyc));
    repeat (5) @(negedge clk);
    chk("frame_cycles_hold", frame_cycles, 32'(exp_cyc));
`else
    chk("frame_cycles_off", frame_cycles, 32'd0);
`endif

    done = 1'b0;
    all_done = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    done = 1'b1;
    iterations = 32'd5;
    max_iterations = 32'd10;
    w = 0;
    while (!fb_if.wr_en && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("pre_rst_wr_en", 32'(fb_if.wr_en), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_wr_en", 32'(fb_if.wr_en), 32'd0);
    chk("async_pixel_count", pixel_count, 32'd0);
    chk("async_frame_done", 32'(frame_done), 32'd0);
    chk("async_frame_cycles", frame_cycles, 32'd0);
    done = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_writer.md
Name: pixel_writer

Overview:
- Consumer end of the iterator result handshake.
- Waits for `done`, captures `iterations`, maps it to an 8-bit colour and writes it to the VGA frame-buffer write port at a raster address.
- Returns a one-cycle `handshake` pulse so the iterator advances to the next point.
- Sits between one iterator and the frame-buffer write port. Raster order matches iterator point order: x increments, wraps at row end, then y increments.

Parameters:
- H_RES, 640, pixels per row.
- V_RES, 480, rows per frame.
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- COLOR_W, 8, pixel colour width.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- done  input  1  iterator result valid; level, held until handshake.
- all_done  input  1  iterator finished all points; level.
- iterations  input  32  iteration count of current point.
- max_iterations  input  32  same value driven to the iterator.
- handshake  output  1  one-cycle pulse: result consumed.
- wr_en  output  1  frame-buffer write request.
- wr_addr  output  ADDR_W  write address.
- wr_data  output  COLOR_W  write colour.
- wr_ack  input  1  frame-buffer accepted the write (may stall arbitrarily).
- pixel_count  output  32  pixels written since reset.
- frame_done  output  1  all points written; held high until rst.
- frame_cycles  output  32  see Optional Feature.

Behaviour:
- Reset (async, rst=1): state S_IDLE; all outputs 0, including addr counter, x/y, pixel_count and the captured colour register. Clearing is immediate, no clock needed. Reset mid-write drops wr_en in the same instant.
- States: S_IDLE, S_CAPTURE, S_WRITE, S_HANDSHAKE, S_FINISHED.
- S_IDLE:
  - done=1 -> S_CAPTURE.
  - else all_done=1 -> S_FINISHED.
  - If both are high, done wins.
- S_CAPTURE (1 cycle): register colour = color_map(iterations, max_iterations) -> S_WRITE.
- S_WRITE:
  - wr_en=1; wr_addr = current addr; wr_data = registered colour. These are stable while waiting.
  - On wr_ack=1 at a clock edge -> S_HANDSHAKE.
  - Same edge: increment pixel_count; advance addr.
- Address advance:
  - addr+1; x+1.
  - If x==H_RES-1: x=0, y+1.
  - If addr==H_RES*V_RES-1: addr=0, x=0, y=0 (frame wrap, no error).
- S_HANDSHAKE (1 cycle): handshake=1 -> S_IDLE. The iterator drops done on the same edge, so there is no double capture.
- S_FINISHED: frame_done=1; all write outputs 0; remains until rst.
- wr_ack outside S_WRITE is ignored.
- Minimum latency: done seen at edge N; wr_en high from cycle N+1 to N+2; wr_ack at N+2 edge gives handshake during cycle N+3.
- Minimum 4 cycles per pixel; each wr_ack stall cycle adds one.
- Colour map (combinational), with b = floor(log2(iterations+1)) clamped to 0..7:
  - iterations >= max_iterations -> 8'h00 (in-set, black).
  - else -> PALETTE[b].
- Unsigned 32-bit compares throughout. max_iterations=0 makes every point black.
- pixel_count wraps modulo 2^32.

Optional Feature:
- Macro: PIXEL_WRITER_CYCLE_COUNT_EN.
- Defined:
  - 32-bit counter increments every clk while state != S_FINISHED and rst=0; it starts on the first edge after reset release.
  - Counter freezes on entry to S_FINISHED.
  - frame_cycles outputs the counter; reset value 0.
- Undefined: no counter logic; frame_cycles tied to 0.

Decomposition:
- Package pixel_writer_pkg: state enum typedef; PALETTE constant (8 x COLOR_W), {8'h00,8'h03,8'h1F,8'h1C,8'hFC,8'hE0,8'hE3,8'hFF}; BLACK constant 8'h00.
- Sub-module color_map: combinational iterations/max_iterations -> colour, including log2 bucket logic. Instantiated once; unit-testable alone.

Test Plan:
- Single point: iterations=1000, max=1000, done=1, wr_ack tied 1 -> wr_addr=0, wr_data=8'h00, handshake pulse 3 cycles after done seen, pixel_count=1.
- Colour buckets, max=1000:
  - iterations=0 -> 8'h00 (b=0).
  - iterations=2 -> 8'h03.
  - iterations=6 -> 8'h1F.
  - iterations=200 -> 8'hFF (b clamped to 7).
- Raster wrap, H_RES=4, V_RES=2, 9 points:
  - addresses 0..7 then 0.
  - x=3 -> next x=0, y=1.
  - pixel_count=9.
- Stall: wr_ack held 0 for 5 cycles -> wr_en, wr_addr, wr_data stable throughout; no handshake until the cycle after ack.
- End: all_done=1 while idle -> frame_done=1, wr_en=0. A later done is ignored. Assert rst mid-S_WRITE -> wr_en=0 immediately, pixel_count=0.
- With PIXEL_WRITER_CYCLE_COUNT_EN, 2 pixels with immediate ack then all_done -> frame_cycles freezes at the entry cycle of S_FINISHED and holds. Without the macro, frame_cycles=0.
